fifo_drain_arbiter: RTL and testbench

- Drains N source std_fifo instances (LATENCY=1 read side) into one shared downstream std_fifo, one pop per cycle.
- Round-robin arbitration with a configurable burst hold.
- Sequences source pops, accounts for the one-cycle read latency, and honours downstream backpressure via the downstream almost_full.
- Sits between per-channel queues and a merged stream (e.g. a shared write-back or egress FIFO).

---
 rtl/fifo_drain_arbiter_pkg.sv | 17 +
 rtl/fifo_drain_arbiter_rr_next_nonempty.sv | 41 ++++
 rtl/fifo_drain_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared definitions for fifo_drain_arbiter: arbiter state encoding and
// the index-width helper used to size source and burst counters.
package fifo_drain_arbiter_pkg;

   // IDLE: no source owns the grant. HOLD: cur owns the grant mid-burst.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Number of bits needed to index 0..n-1, never less than one bit so that
   // degenerate configurations (n = 1 or 2) still get a usable vector.
   function automatic int idx_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_drain_arbiter_rr_next_nonempty.sv
// rr_next_nonempty: combinational rotate-and-priority search.
// Scans sources start, start+1, ... start+N-1 (modulo N, so non-power-of-2 N
// wraps correctly) and reports the first one whose empty flag is low.
module rr_next_nonempty #(
   parameter int N       = 4,
   parameter int N_WIDTH = 1
) (
   input  logic [N-1:0]   empty,
   input  logic [N_WIDTH:0] start,
   output logic           found,
   output logic [N_WIDTH:0] index
);

   localparam int IW = N_WIDTH + 1;
   localparam int SW = N_WIDTH + 2;

   logic [IW-1:0] cand_idx [N];
   logic [N-1:0]  hit;

   // Candidate gi is the source visited gi steps after start.
   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [SW-1:0] sum;
      assign sum          = {1'b0, start} + SW'(gi);
      assign cand_idx[gi] = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : sum[IW-1:0];
      assign hit[gi]      = ~empty[cand_idx[gi]];
   end

   // Lowest rotation distance wins: scan from the far end so the nearest
   // non-empty candidate overwrites everything after it.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k]) begin
            found = 1'b1;
            index = cand_idx[k];
         end
      end
   end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: drains N latency-1 source FIFOs into one downstream
// FIFO, one pop per cycle, round-robin with a burst hold of up to BURST pops.
// Pops are combinational; the matching push is issued one cycle later when the
// source read data is valid, so back-to-back transfers never leave a gap.
// Optional per-source grant counters are built when FIFO_DRAIN_ARB_STATS_EN is
// defined (adds the grant_count output).
module fifo_drain_arbiter
   import fifo_drain_arbiter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int N           = 4,
   parameter int N_WIDTH     = idx_bits(N) - 1,
   parameter int BURST       = 4,
   parameter int BURST_WIDTH = idx_bits(BURST) - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N-1:0]         src_empty,
   input  logic [N*WIDTH-1:0]   src_q,
   output logic [N-1:0]         src_pop,
   input  logic                 dst_almost_full,
   output logic                 dst_push,
   output logic [WIDTH-1:0]     dst_d,
   output logic [N_WIDTH:0]     dst_src,
   output logic                 busy
`ifdef FIFO_DRAIN_ARB_STATS_EN
   ,
   output logic [N*32-1:0]      grant_count
`endif
);

   localparam int IW = N_WIDTH + 1;
   localparam int BW = BURST_WIDTH + 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

   arb_state_e     state_q, state_d;
   logic [IW-1:0]  cur_q, cur_d;
   logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
   logic           inflight_q, inflight_d;
   logic [IW-1:0]  dst_src_q, dst_src_d;

   logic           go;
   logic           pop_valid;
   logic [IW-1:0]  pop_idx;
   logic [IW-1:0]  search_start;
   logic           search_found;
   logic [IW-1:0]  search_idx;
   logic [WIDTH-1:0] src_word [N];

   // Reset is folded into go so src_pop drops the moment rst goes low,
   // not at the next clock edge.
   assign go = enable & ~dst_almost_full & rst;

   // The current owner is visited last, so rotation starts one past it.
   assign search_start = (cur_q == LAST_IDX) ? '0 : cur_q + IW'(1);

   rr_next_nonempty #(
      .N       (N),
      .N_WIDTH (N_WIDTH)
   ) u_search (
      .empty (src_empty),
      .start (search_start),
      .found (search_found),
      .index (search_idx)
   );

   // Next-state: continue the burst while the owner has data and budget,
   // otherwise hand the grant to the next non-empty source.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      burst_cnt_d = burst_cnt_q;
      pop_valid   = 1'b0;
      pop_idx     = cur_q;
      if (go) begin
         if (state_q == HOLD && !src_empty[cur_q] && burst_cnt_q < BURST_LAST) begin
            pop_valid   = 1'b1;
            pop_idx     = cur_q;
            burst_cnt_d = burst_cnt_q + BW'(1);
         end else if (search_found) begin
            pop_valid   = 1'b1;
            pop_idx     = search_idx;
            cur_d       = search_idx;
            burst_cnt_d = '0;
            state_d     = HOLD;
         end else begin
            state_d = IDLE;
         end
      end
      inflight_d = pop_valid;
      dst_src_d  = pop_valid ? pop_idx : dst_src_q;
   end

   // One-hot pop strobe for the selected source.
   always_comb begin
      src_pop = '0;
      if (pop_valid) begin
         src_pop[pop_idx] = 1'b1;
      end
   end

   // Arbiter state and the one-word in-flight tracker.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         burst_cnt_q <= '0;
         inflight_q  <= 1'b0;
         dst_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         burst_cnt_q <= burst_cnt_d;
         inflight_q  <= inflight_d;
         dst_src_q   <= dst_src_d;
      end
   end

   // Unflatten the source read buses for the output mux.
   for (genvar gi = 0; gi < N; gi++) begin : g_word
      assign src_word[gi] = src_q[gi*WIDTH +: WIDTH];
   end

   // The source popped last cycle presents its word now, so dst_d is a plain
   // mux on the registered source index; the push itself is the registered
   // in-flight flag and is never cancelled by late backpressure.
   assign dst_push = inflight_q;
   assign dst_src  = dst_src_q;
   assign dst_d    = src_word[dst_src_q];
   assign busy     = (state_q == HOLD) | inflight_q;

`ifdef FIFO_DRAIN_ARB_STATS_EN
   for (genvar gi = 0; gi < N; gi++) begin : g_stats
      logic [31:0] grant_cnt_q;
      // Saturating count of pops granted to source gi.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            grant_cnt_q <= '0;
         end else if (src_pop[gi] && grant_cnt_q != 32'hFFFF_FFFF) begin
            grant_cnt_q <= grant_cnt_q + 32'd1;
         end
      end
      assign grant_count[gi*32 +: 32] = grant_cnt_q;
   end
`else
   // Grant statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter. Two instances share clk/rst:
// index 0 uses BURST=4, index 1 uses BURST=1 (pure round-robin).
// Each instance is fed by small behavioural latency-1 source FIFO models.
module tb_fifo_drain_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int NW = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              en_v [2];
   logic              af_v [2];
   logic [N-1:0]      empty_v [2];
   logic [N*W-1:0]    q_v [2];
   logic [N-1:0]      pop_v [2];
   logic              push_v [2];
   logic [W-1:0]      d_v [2];
   logic [NW:0]       src_v [2];
   logic              busy_v [2];
`ifdef FIFO_DRAIN_ARB_STATS_EN
   logic [N*32-1:0]   gc_v [2];
`endif

   // Source FIFO models
   logic [W-1:0] mem [2][N][16];
   logic [W-1:0] qreg [2][N] = '{default: '0};
   int wr_ptr [2][N] = '{default: 0};
   int rd_ptr [2][N] = '{default: 0};
   int underflow = 0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_no = 0;
   int prev_s [2] = '{-1, -1};
   int prev_n [2] = '{0, 0};
   int exp_rd [2][N] = '{default: 0};

   fifo_drain_arbiter #(.WIDTH(W), .N(N), .BURST(4)) u_dut_a (
      .clk             (clk),
      .rst             (rst_n),
      .enable          (en_v[0]),
      .src_empty       (empty_v[0]),
      .src_q           (q_v[0]),
      .src_pop         (pop_v[0]),
      .dst_almost_full (af_v[0]),
      .dst_push        (push_v[0]),
      .dst_d           (d_v[0]),
      .dst_src         (src_v[0]),
      .busy            (busy_v[0])
`ifdef FIFO_DRAIN_ARB_STATS_EN
      ,
      .grant_count     (gc_v[0])
`endif
   );

   fifo_drain_arbiter #(.WIDTH(W), .N(N), .BURST(1)) u_dut_b (
      .clk             (clk),
      .rst             (rst_n),
      .enable          (en_v[1]),
      .src_empty       (empty_v[1]),
      .src_q           (q_v[1]),
      .src_pop         (pop_v[1]),
      .dst_almost_full (af_v[1]),
      .dst_push        (push_v[1]),
      .dst_d           (d_v[1]),
      .dst_src         (src_v[1]),
      .busy            (busy_v[1])
`ifdef FIFO_DRAIN_ARB_STATS_EN
      ,
      .grant_count     (gc_v[1])
`endif
   );

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            empty_v[d][i]       = (wr_ptr[d][i] == rd_ptr[d][i]);
            q_v[d][i*W +: W]    = qreg[d][i];
         end
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            if (pop_v[d][i]) begin
               if (wr_ptr[d][i] == rd_ptr[d][i]) underflow <= underflow + 1;
               qreg[d][i]   <= mem[d][i][rd_ptr[d][i] % 16];
               rd_ptr[d][i] <= rd_ptr[d][i] + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Word k of source s carries {s, k} so data identifies its origin.
   task automatic load(input int d, input int s, input int n);
      for (int k = 0; k < n; k++) begin
         mem[d][s][wr_ptr[d][s] % 16] = 8'((s << 4) | wr_ptr[d][s]);
         wr_ptr[d][s] = wr_ptr[d][s] + 1;
      end
   endtask

   // Called at a negedge with inputs set. Checks the pop expected in this
   // cycle and the push caused by the previous cycle's pop, then advances.
   task automatic cyc(input int d, input int pop_s);
      logic [63:0] exp_pop;
      #1;
      exp_pop = (pop_s >= 0) ? (64'd1 << pop_s) : 64'd0;
      check($sformatf("dut%0d c%0d src_pop", d, cyc_no), 64'(pop_v[d]), exp_pop);
      check($sformatf("dut%0d c%0d dst_push", d, cyc_no), 64'(push_v[d]), 64'(prev_s[d] >= 0));
      if (prev_s[d] >= 0) begin
         check($sformatf("dut%0d c%0d dst_src", d, cyc_no), 64'(src_v[d]), 64'(prev_s[d]));
         check($sformatf("dut%0d c%0d dst_d", d, cyc_no), 64'(d_v[d]),
               64'(8'((prev_s[d] << 4) | prev_n[d])));
         $display("push dut%0d cycle %0d src %0d data %0h", d, cyc_no, src_v[d], d_v[d]);
      end
      prev_s[d] = pop_s;
      if (pop_s >= 0) begin
         prev_n[d] = exp_rd[d][pop_s];
         exp_rd[d][pop_s] = exp_rd[d][pop_s] + 1;
      end
      cyc_no++;
      @(negedge clk);
   endtask

   initial begin
      en_v[0] = 1'b0; en_v[1] = 1'b0;
      af_v[0] = 1'b0; af_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset dst_push", 64'(push_v[0]), 64'd0);
      check("reset busy", 64'(busy_v[0]), 64'd0);
      check("reset src_pop", 64'(pop_v[0]), 64'd0);
      check("reset dst_src", 64'(src_v[0]), 64'd0);
      check("reset dst_d", 64'(d_v[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Pure round-robin over four sources, two words each
      for (int s = 0; s < N; s++) load(1, s, 2);
      en_v[1] = 1'b1;
      cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 0);
      cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 0);
      cyc(1, -1); cyc(1, -1);
      #1;
      check("rr idle busy", 64'(busy_v[1]), 64'd0);
`ifdef FIFO_DRAIN_ARB_STATS_EN
      for (int s = 0; s < N; s++)
         check($sformatf("grant_count[%0d]", s), 64'(gc_v[1][s*32 +: 32]), 64'd2);
`endif
      en_v[1] = 1'b0;

      // Burst of 4 from source 2, then source 3, then the rest of source 2
      load(0, 2, 6);
      load(0, 3, 1);
      en_v[0] = 1'b1;
      cyc(0, 2); cyc(0, 2); cyc(0, 2); cyc(0, 2);
      cyc(0, 3); cyc(0, 2); cyc(0, 2);
      cyc(0, -1); cyc(0, -1);

      // Backpressure mid-burst: in-flight word still lands, burst count frozen
      load(0, 0, 5);
      load(0, 1, 2);
      cyc(0, 0); cyc(0, 0);
      af_v[0] = 1'b1;
      cyc(0, -1); cyc(0, -1);
      #1;
      check("af hold busy", 64'(busy_v[0]), 64'd1);
      af_v[0] = 1'b0;
      cyc(0, 0); cyc(0, 0); cyc(0, 1); cyc(0, 1); cyc(0, 0);
      cyc(0, -1);

      // All empty, then a single word arrives in source 1
      cyc(0, -1);
      #1;
      check("empty busy", 64'(busy_v[0]), 64'd0);
      load(0, 1, 1);
      cyc(0, 1); cyc(0, -1); cyc(0, -1);

      // Reset mid-burst with a word in flight
      load(0, 2, 4);
      cyc(0, 2); cyc(0, 2);
      rst_n = 1'b0;
      #1;
      check("async rst dst_push", 64'(push_v[0]), 64'd0);
      check("async rst src_pop", 64'(pop_v[0]), 64'd0);
      check("async rst busy", 64'(busy_v[0]), 64'd0);
      prev_s[0] = -1;
      load(0, 0, 1);
      load(0, 1, 1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1); cyc(0, 2); cyc(0, 2); cyc(0, 0);
      cyc(0, -1); cyc(0, -1);

      check("no source underflow", 64'(underflow), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
